// File: rtl/mips32_multicycle_ctrl.sv
// Multicycle MIPS32 control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, counts retirements and guards the memory handshake.
module mips32_multicycle_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             eq,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             mem_err,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    s_fetch  = 3'd0,
    s_decode = 3'd1,
    s_exec   = 3'd2,
    s_mem    = 3'd3,
    s_wb     = 3'd4,
    s_halted = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int unsigned  TW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t          cur, nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic            retire;
  logic            set_err;
  logic            waiting;
  logic            tmo;
  logic            funct_ok;
  logic            op_ok;
  logic [3:0]      alu_r;

  // R-type funct decode
  always_comb begin
    funct_ok = 1'b1;
    alu_r    = ALU_ADD;
    case (funct)
      6'h20:   alu_r = ALU_ADD;
      6'h22:   alu_r = ALU_SUB;
      6'h24:   alu_r = ALU_AND;
      6'h25:   alu_r = ALU_OR;
      6'h2A:   alu_r = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_RTYPE: op_ok = funct_ok;
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: op_ok = 1'b1;
      default:  op_ok = 1'b0;
    endcase
  end

  assign waiting = ((cur == s_fetch) || (cur == s_mem)) && !mem_ready;
  assign tmo     = (MEM_TIMEOUT != 0) && waiting && (tcnt == TLIM);

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = 4'b0000;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    nxt        = cur;
    retire     = 1'b0;
    set_err    = 1'b0;

    // Reset and a timed-out access both suppress every strobe for the cycle.
    if (rst) begin
      nxt = s_fetch;
    end else if (tmo) begin
      nxt     = s_halted;
      set_err = 1'b1;
    end else begin
      case (cur)
        s_fetch: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_ctrl  = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt      = s_decode;
          end
        end
        s_decode: begin
          alu_src_b = 2'b11;
          alu_ctrl  = ALU_ADD;
          if (opcode == OP_HALT) begin
            nxt = s_halted;
          end else if (!op_ok) begin
            illegal = 1'b1;
            nxt     = s_fetch;
          end else begin
            nxt = s_exec;
          end
        end
        s_exec: begin
          case (opcode)
            OP_RTYPE: begin
              alu_src_a = 1'b1;
              alu_ctrl  = alu_r;
              nxt       = s_wb;
            end
            OP_LW, OP_SW, OP_ADDI: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              alu_ctrl  = ALU_ADD;
              nxt       = (opcode == OP_ADDI) ? s_wb : s_mem;
            end
            OP_BEQ, OP_BNE: begin
              alu_src_a = 1'b1;
              alu_ctrl  = ALU_SUB;
              pc_src    = 2'b01;
              pc_write  = (opcode == OP_BEQ) ? eq : !eq;
              nxt       = s_fetch;
              retire    = 1'b1;
            end
            OP_J: begin
              pc_write = 1'b1;
              pc_src   = 2'b10;
              nxt      = s_fetch;
              retire   = 1'b1;
            end
            default: nxt = s_fetch;
          endcase
        end
        s_mem: begin
          iord      = 1'b1;
          mem_read  = (opcode == OP_LW);
          mem_write = (opcode == OP_SW);
          if (mem_ready) begin
            if (opcode == OP_LW) begin
              nxt = s_wb;
            end else begin
              nxt    = s_fetch;
              retire = (opcode == OP_SW);
            end
          end
        end
        s_wb: begin
          reg_write  = 1'b1;
          reg_dst    = (opcode == OP_RTYPE);
          mem_to_reg = (opcode == OP_LW);
          nxt        = s_fetch;
          retire     = 1'b1;
        end
        s_halted: nxt = s_halted;
        default:  nxt = s_fetch;
      endcase
    end
  end

  // Wait counter only runs while the FSM sits in a memory state without a reply.
  assign tcnt_nxt = (waiting && (nxt == cur)) ? tcnt + TW'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= s_fetch;
      instr_count <= '0;
      mem_err     <= 1'b0;
      tcnt        <= '0;
    end else begin
      cur  <= nxt;
      tcnt <= tcnt_nxt;
      if (retire)  instr_count <= instr_count + CNT_W'(1);
      if (set_err) mem_err     <= 1'b1;
    end
  end

  assign state  = cur;
  assign halted = (cur == s_halted);

endmodule

// File: tb/tb_mips32_multicycle_ctrl.sv
// Scoreboard bench for mips32_multicycle_ctrl: each test queues per-cycle
// stimulus with its expected outputs, then replays the queue against the DUT.
module tb_mips32_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       eq, mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctrl;
  logic       reg_write, reg_dst, mem_to_reg, illegal, mem_err, halted;
  logic [2:0] state;
  logic [3:0] instr_count;

  always #5 clk = ~clk;

  mips32_multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .eq(eq),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .mem_err(mem_err), .halted(halted), .state(state),
    .instr_count(instr_count)
  );

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        e;
    logic        rdy;
    logic [26:0] exp;
    string       tag;
  } ent_t;

  ent_t        q[$];
  ent_t        x;
  int          total = 0;
  int          bad = 0;
  logic [3:0]  ecnt;
  logic [26:0] obs;

  logic [17:0] c_zero, c_frdy, c_fwait, c_dec, c_dec_ill, c_ex_i, c_ex_j;
  logic [17:0] c_mem_lw, c_mem_sw, c_wb_r, c_wb_i, c_wb_l;

  // {mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
  //  alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg, illegal}
  function automatic logic [17:0] cv(input logic mr, mw, io, irw, pcw,
                                     input logic [1:0] ps, input logic asa,
                                     input logic [1:0] asb, input logic [3:0] alu,
                                     input logic rw, rd, m2r, ill);
    return {mr, mw, io, irw, pcw, ps, asa, asb, alu, rw, rd, m2r, ill};
  endfunction

  task automatic push(input logic r, input logic [5:0] op, fn, input logic e, rdy,
                      input logic [2:0] st, input logic [17:0] c, input logic err,
                      input string tag);
    ent_t n;
    n.r = r; n.op = op; n.fn = fn; n.e = e; n.rdy = rdy; n.tag = tag;
    n.exp = {st, c, ecnt, err, st == 3'd5};
    q.push_back(n);
  endtask

  task automatic pfd(input logic [5:0] op, fn);
    push(1'b0, op, fn, 1'b0, 1'b1, 3'd0, c_frdy, 1'b0, "fetch");
    push(1'b0, op, fn, 1'b0, 1'b1, 3'd1, c_dec, 1'b0, "decode");
  endtask

  task automatic drive(input ent_t n);
    rst = n.r; opcode = n.op; funct = n.fn; eq = n.e; mem_ready = n.rdy;
    @(negedge clk);
    obs = {state, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg,
           illegal, instr_count, mem_err, halted};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    push(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 3'd0, c_zero, 1'b0, "rst_hold");
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL reset/%s got=%h want=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic test_add();
    pfd(6'h00, 6'h20);
    push(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 3'd2, cv(0,0,0,0,0,2'b00,1,2'b00,4'b0010,0,0,0,0), 1'b0, "exec");
    push(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 3'd4, c_wb_r, 1'b0, "wb");
    ecnt++;
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL add/%s got=%h want=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic test_rtype_alu();
    logic [5:0] fns[4];
    logic [3:0] alus[4];
    fns  = '{6'h22, 6'h24, 6'h25, 6'h2A};
    alus = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      pfd(6'h00, fns[i]);
      push(1'b0, 6'h00, fns[i], 1'b0, 1'b1, 3'd2, cv(0,0,0,0,0,2'b00,1,2'b00,alus[i],0,0,0,0), 1'b0, "exec");
      push(1'b0, 6'h00, fns[i], 1'b0, 1'b1, 3'd4, c_wb_r, 1'b0, "wb");
      ecnt++;
    end
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL ralu/%s fn=%h got=%h want=%h", x.tag, x.fn, obs, x.exp);
      end
    end
  endtask

  task automatic test_lw();
    push(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 3'd0, c_fwait, 1'b0, "fetch_wait");
    push(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 3'd0, c_fwait, 1'b0, "fetch_wait");
    pfd(6'h23, 6'h00);
    push(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 3'd2, c_ex_i, 1'b0, "exec");
    for (int i = 0; i < 3; i++)
      push(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 3'd3, c_mem_lw, 1'b0, "mem_wait");
    push(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 3'd3, c_mem_lw, 1'b0, "mem_done");
    push(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 3'd4, c_wb_l, 1'b0, "wb");
    ecnt++;
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL lw/%s got=%h want=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[4];
    logic       eqs[4];
    logic       pcw[4];
    ops = '{6'h04, 6'h04, 6'h05, 6'h05};
    eqs = '{1'b1, 1'b0, 1'b0, 1'b1};
    pcw = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      pfd(ops[i], 6'h00);
      push(1'b0, ops[i], 6'h00, eqs[i], 1'b1, 3'd2,
           cv(0,0,0,0,pcw[i],2'b01,1,2'b00,4'b0110,0,0,0,0), 1'b0, "exec");
      ecnt++;
    end
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL branch/%s op=%h eq=%b got=%h want=%h", x.tag, x.op, x.e, obs, x.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    pfd(6'h08, 6'h00);
    push(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 3'd2, c_ex_i, 1'b0, "addi_exec");
    push(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 3'd4, c_wb_i, 1'b0, "addi_wb");
    ecnt++;
    pfd(6'h2B, 6'h00);
    push(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 3'd2, c_ex_i, 1'b0, "sw_exec");
    push(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 3'd3, c_mem_sw, 1'b0, "sw_mem");
    ecnt++;
    pfd(6'h02, 6'h00);
    push(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, 3'd2, c_ex_j, 1'b0, "j_exec");
    ecnt++;
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL b2b/%s got=%h want=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic test_illegal();
    push(1'b0, 6'h11, 6'h20, 1'b0, 1'b1, 3'd0, c_frdy, 1'b0, "op_fetch");
    push(1'b0, 6'h11, 6'h20, 1'b0, 1'b1, 3'd1, c_dec_ill, 1'b0, "op_decode");
    push(1'b0, 6'h00, 6'h07, 1'b0, 1'b1, 3'd0, c_frdy, 1'b0, "fn_fetch");
    push(1'b0, 6'h00, 6'h07, 1'b0, 1'b1, 3'd1, c_dec_ill, 1'b0, "fn_decode");
    push(1'b0, 6'h00, 6'h07, 1'b0, 1'b0, 3'd0, c_fwait, 1'b0, "after");
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL illegal/%s got=%h want=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin
      pfd(6'h02, 6'h00);
      push(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, 3'd2, c_ex_j, 1'b0, "j_exec");
      ecnt++;
    end
    push(1'b0, 6'h02, 6'h00, 1'b0, 1'b0, 3'd0, c_fwait, 1'b0, "wrapped");
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL wrap/%s cnt_want=%0d got=%h want=%h", x.tag, x.exp[5:2], obs, x.exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    pfd(6'h2B, 6'h00);
    push(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 3'd2, c_ex_i, 1'b0, "exec");
    push(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 3'd3, c_mem_sw, 1'b0, "mem_wait");
    push(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 3'd3, c_zero, 1'b0, "rst_in_mem");
    ecnt = '0;
    push(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 3'd0, c_fwait, 1'b0, "resumed");
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL rstmid/%s got=%h want=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic test_halt();
    pfd(6'h02, 6'h00);
    push(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, 3'd2, c_ex_j, 1'b0, "j_exec");
    ecnt++;
    pfd(6'h3F, 6'h00);
    for (int i = 0; i < 20; i++)
      push(1'b0, 6'(i * 7), 6'h20, i[0], i[1], 3'd5, c_zero, 1'b0, "halted");
    push(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd5, c_zero, 1'b0, "rst");
    ecnt = '0;
    push(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'd0, c_fwait, 1'b0, "after_rst");
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL halt/%s got=%h want=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic test_timeout();
    push(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 3'd0, c_zero, 1'b0, "rst");
    for (int i = 0; i < 3; i++)
      push(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'd0, c_fwait, 1'b0, "fetch_wait");
    push(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'd0, c_zero, 1'b0, "expire");
    push(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 3'd5, c_zero, 1'b1, "halted");
    push(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'd5, c_zero, 1'b1, "sticky");
    push(1'b1, 6'h00, 6'h00, 1'b0, 1'b1, 3'd5, c_zero, 1'b1, "rst");
    push(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 3'd0, c_frdy, 1'b0, "cleared");
    while (q.size() > 0) begin
      x = q.pop_front(); drive(x); total++;
      if (obs !== x.exp) begin
        bad++; $display("FAIL timeout/%s got=%h want=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  initial begin
    c_zero    = '0;
    c_frdy    = cv(1,0,0,1,1,2'b00,0,2'b01,4'b0010,0,0,0,0);
    c_fwait   = cv(1,0,0,0,0,2'b00,0,2'b01,4'b0010,0,0,0,0);
    c_dec     = cv(0,0,0,0,0,2'b00,0,2'b11,4'b0010,0,0,0,0);
    c_dec_ill = cv(0,0,0,0,0,2'b00,0,2'b11,4'b0010,0,0,0,1);
    c_ex_i    = cv(0,0,0,0,0,2'b00,1,2'b10,4'b0010,0,0,0,0);
    c_ex_j    = cv(0,0,0,0,1,2'b10,0,2'b00,4'b0000,0,0,0,0);
    c_mem_lw  = cv(1,0,1,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0);
    c_mem_sw  = cv(0,1,1,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0);
    c_wb_r    = cv(0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,1,0,0);
    c_wb_i    = cv(0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,0,0,0);
    c_wb_l    = cv(0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,0,1,0);
    ecnt      = '0;

    rst = 1'b1; opcode = '0; funct = '0; eq = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    test_reset();
    test_add();
    test_rtype_alu();
    test_lw();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_wrap();
    test_reset_mid();
    test_halt();
    test_timeout();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips32_multicycle_ctrl.md
Name: mips32_multicycle_ctrl

Overview:
- Multicycle sequencer for the MIPS32 datapath: one FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the PC-write, memory, register-file and ALU control strobes for the shared single-port memory.
- Resolves BEQ/BNE from the datapath `eq` flag.
- Counts retired instructions and detects memory-handshake timeouts.

Parameters:
- CNT_W, 32: width of retired-instruction counter.
- MEM_TIMEOUT, 16: max cycles waiting for mem_ready per access; 0 disables timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction returns to FETCH
- funct  in  6  IR[5:0]
- eq  in  1  datapath compare, 1 when rs==rt
- mem_ready  in  1  memory access complete this cycle
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  2  00 = ALU result (PC+4), 01 = ALUOut (branch target), 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- reg_write  out  1  register-file write
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- mem_err  out  1  sticky; memory timeout occurred
- halted  out  1  FSM in HALTED
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (sync):
  - state=FETCH; instr_count=0; mem_err=0; timeout counter=0.
  - While rst=1, every strobe output is forced 0.
- Outputs are combinational from state, opcode/funct, eq and mem_ready. Any strobe not listed for a state is 0; mux selects not listed are don't-care, driven 0.
- Supported instructions:
  - R-type (op 00) with funct 20 ADD, 22 SUB, 24 AND, 25 OR, 2A SLT.
  - LW 23, SW 2B, BEQ 04, BNE 05, ADDI 08, J 02, HALT 3F.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next state DECODE. Otherwise stay.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target into ALUOut).
  - HALT -> HALTED.
  - Unsupported opcode, or R-type with unsupported funct -> illegal=1, next FETCH. Not counted.
  - All other instructions -> EXEC.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=00, alu_ctrl per funct, -> WB.
  - LW/SW/ADDI: alu_src_a=1, alu_src_b=10, ADD. LW/SW -> MEM; ADDI -> WB.
  - BEQ/BNE: alu_src_a=1, alu_src_b=00, SUB, pc_src=01. pc_write = eq (BEQ) or ~eq (BNE). -> FETCH, counted.
  - J: pc_write=1, pc_src=10, -> FETCH, counted.
- MEM:
  - iord=1; mem_read=1 for LW, mem_write=1 for SW.
  - On mem_ready: LW -> WB; SW -> FETCH, counted. Otherwise stay.
- WB:
  - reg_write=1, -> FETCH, counted.
  - R-type: reg_dst=1, mem_to_reg=0. ADDI: reg_dst=0, mem_to_reg=0. LW: reg_dst=0, mem_to_reg=1.
- Counting:
  - instr_count increments by 1 on the cycle the FSM leaves for FETCH after a completed instruction (including an untaken branch).
  - Wraps modulo 2^CNT_W.
- Timeout:
  - Counter increments each cycle in FETCH or MEM with mem_ready=0; it clears on mem_ready=1 or on a state change.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 with mem_ready still 0: mem_err<=1, next HALTED, no strobes that cycle.
  - If mem_ready=1 on that same cycle, the access completes normally.
- HALTED:
  - Absorbing; all strobes 0; halted=1. Exit only via rst.
- Reset mid-instruction aborts it; no strobe is asserted in the rst cycle, and execution resumes at FETCH.

Test Plan:
- ADD R-type, mem_ready tied 1 -> states 0,1,2,4,0 (four cycles); reg_write=1 with reg_dst=1 in WB; alu_ctrl=0010 in EXEC; instr_count 0->1.
- LW, mem_ready delayed 3 cycles in MEM -> MEM held for 4 cycles with iord=1, mem_read=1; WB has mem_to_reg=1, reg_dst=0; count +1.
- BEQ with eq=1, then BEQ with eq=0, then BNE with eq=0 -> pc_write in EXEC is 1, 0, 1 respectively, pc_src=01 each time; count +3 in total.
- Opcode 0x3F -> HALTED after DECODE, halted=1, all strobes 0 for 20 cycles; rst=1 for one cycle -> state=0, instr_count=0.
- Opcode 0x11, then R-type funct 0x07 -> illegal pulses for one cycle in DECODE each time, next state FETCH, count unchanged.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> after 4 waiting cycles mem_err=1, state=5; rst asserted mid-MEM on an SW -> mem_write=0 in that cycle, state=0 next.
